// File: rtl/ex_pkg.sv
// Shared types and default sizing for the MIPS execute stage.
package ex_pkg;

   localparam int DEF_XLEN       = 32;
   localparam int DEF_MUL_CYCLES = 32;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_NOR = 3'b110,
      ALU_MUL = 3'b111
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } ex_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle; low XLEN
// bits of the product are presented combinationally during the final step.
module ex_mul_seq
   import ex_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
   input  logic            clock__i,
   input  logic            reset_n__i,
   input  logic            start__i,
   input  logic [XLEN-1:0] op_a__i,
   input  logic [XLEN-1:0] op_b__i,
   output logic            busy__o,
   output logic            done__o,
   output logic [XLEN-1:0] result__o
);

   localparam int CW = $clog2(MUL_CYCLES);

   ex_state_t       state;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] mcnd;
   logic [XLEN-1:0] mplr;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] acc_next;

   assign acc_next  = acc + (mplr[0] ? mcnd : '0);
   assign busy__o   = (state == BUSY);
   assign done__o   = busy__o && (count == CW'(MUL_CYCLES - 1));
   assign result__o = acc_next;

   always_ff @(posedge clock__i or negedge reset_n__i) begin
      if (!reset_n__i) begin
         state <= IDLE;
         count <= '0;
         mcnd  <= '0;
         mplr  <= '0;
         acc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start__i) begin
                  mcnd  <= op_a__i;
                  mplr  <= op_b__i;
                  acc   <= '0;
                  count <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc  <= acc_next;
               mcnd <= mcnd << 1;
               mplr <= mplr >> 1;
               if (done__o) begin
                  count <= '0;
                  state <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU and the EX/MEM register.
// Define EX_MUL_EN to include the iterative multiplier and its stall logic.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
   input  logic            clock__i,
   input  logic            reset_n__i,
   input  logic            RegWrite__i,
   input  logic            MemToReg__i,
   input  logic            MemRead__i,
   input  logic            MemWrite__i,
   input  logic            ALUSrc__i,
   input  logic            RegDst__i,
   input  logic [2:0]      ALUOp__i,
   input  logic [XLEN-1:0] RegRsData__i,
   input  logic [XLEN-1:0] RegRtData__i,
   input  logic [XLEN-1:0] Immediate__i,
   input  logic [4:0]      InstrRsAddr__i,
   input  logic [4:0]      InstrRtAddr__i,
   input  logic [4:0]      InstrRdAddr__i,
   input  logic            WbRegWrite__i,
   input  logic [4:0]      WbAddr__i,
   input  logic [XLEN-1:0] WbData__i,
   output logic            RegWrite__o,
   output logic            MemToReg__o,
   output logic            MemRead__o,
   output logic            MemWrite__o,
   output logic [XLEN-1:0] ALUResult__o,
   output logic [XLEN-1:0] StoreData__o,
   output logic [4:0]      DestAddr__o,
   output logic            Stall__o
);

   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [4:0]      addr,
      input logic [XLEN-1:0] idex_val,
      input logic            mem_we,
      input logic [4:0]      mem_addr,
      input logic [XLEN-1:0] mem_val,
      input logic            wb_we,
      input logic [4:0]      wb_addr,
      input logic [XLEN-1:0] wb_val
   );
      if (addr == 5'd0)                      return idex_val;
      else if (mem_we && (mem_addr == addr)) return mem_val;
      else if (wb_we && (wb_addr == addr))   return wb_val;
      else                                   return idex_val;
   endfunction

   alu_op_t                op;
   logic [XLEN-1:0]        rs_fwd;
   logic [XLEN-1:0]        rt_fwd;
   logic [XLEN-1:0]        op_b;
   logic signed [XLEN-1:0] rs_s;
   logic signed [XLEN-1:0] op_b_s;
   logic [XLEN-1:0]        mul_out;
   logic [XLEN-1:0]        alu_res;
   logic                   stall;

   assign op     = alu_op_t'(ALUOp__i);
   assign rs_fwd = fwd_sel(InstrRsAddr__i, RegRsData__i, RegWrite__o, DestAddr__o,
                           ALUResult__o, WbRegWrite__i, WbAddr__i, WbData__i);
   assign rt_fwd = fwd_sel(InstrRtAddr__i, RegRtData__i, RegWrite__o, DestAddr__o,
                           ALUResult__o, WbRegWrite__i, WbAddr__i, WbData__i);
   assign op_b   = ALUSrc__i ? Immediate__i : rt_fwd;
   assign rs_s   = rs_fwd;
   assign op_b_s = op_b;

`ifdef EX_MUL_EN
   logic            mul_start;
   logic            mul_busy;
   logic            mul_done;
   logic [XLEN-1:0] mul_res;

   // Operands are captured only on acceptance, so later forwarding changes are ignored.
   assign mul_start = (op == ALU_MUL) && !mul_busy;

   ex_mul_seq #(
      .XLEN       (XLEN),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clock__i   (clock__i),
      .reset_n__i (reset_n__i),
      .start__i   (mul_start),
      .op_a__i    (rs_fwd),
      .op_b__i    (op_b),
      .busy__o    (mul_busy),
      .done__o    (mul_done),
      .result__o  (mul_res)
   );

   assign stall   = mul_start || (mul_busy && !mul_done);
   assign mul_out = mul_res;
`else
   assign stall   = 1'b0;
   assign mul_out = '0;
`endif

   assign Stall__o = stall;

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD: alu_res = rs_fwd + op_b;
         ALU_SUB: alu_res = rs_fwd - op_b;
         ALU_AND: alu_res = rs_fwd & op_b;
         ALU_OR:  alu_res = rs_fwd | op_b;
         ALU_XOR: alu_res = rs_fwd ^ op_b;
         ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, (rs_s < op_b_s)};
         ALU_NOR: alu_res = ~(rs_fwd | op_b);
         ALU_MUL: alu_res = mul_out;
      endcase
   end

   // EX/MEM register; a stall pushes a bubble downstream.
   always_ff @(posedge clock__i or negedge reset_n__i) begin
      if (!reset_n__i) begin
         RegWrite__o  <= 1'b0;
         MemToReg__o  <= 1'b0;
         MemRead__o   <= 1'b0;
         MemWrite__o  <= 1'b0;
         ALUResult__o <= '0;
         StoreData__o <= '0;
         DestAddr__o  <= '0;
      end else if (stall) begin
         RegWrite__o  <= 1'b0;
         MemToReg__o  <= 1'b0;
         MemRead__o   <= 1'b0;
         MemWrite__o  <= 1'b0;
         ALUResult__o <= '0;
         StoreData__o <= '0;
         DestAddr__o  <= '0;
      end else begin
         RegWrite__o  <= RegWrite__i;
         MemToReg__o  <= MemToReg__i;
         MemRead__o   <= MemRead__i;
         MemWrite__o  <= MemWrite__i;
         ALUResult__o <= alu_res;
         StoreData__o <= rt_fwd;
         DestAddr__o  <= RegDst__i ? InstrRdAddr__i : InstrRtAddr__i;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; multiplier scenarios run when EX_MUL_EN is defined.
module tb_ex_stage;

   logic        clock, reset_n;
   logic        rw, m2r, mr, mw, alusrc, regdst;
   logic [2:0]  aluop;
   logic [31:0] rs_d, rt_d, imm;
   logic [4:0]  rs_a, rt_a, rd_a;
   logic        wb_we;
   logic [4:0]  wb_a;
   logic [31:0] wb_d;
   logic        rw_o, m2r_o, mr_o, mw_o;
   logic [31:0] res_o, st_o;
   logic [4:0]  dst_o;
   logic        stall;

   int total = 0;
   int bad   = 0;
   int stalls, bub;

   ex_stage dut (
      .clock__i       (clock),
      .reset_n__i     (reset_n),
      .RegWrite__i    (rw),
      .MemToReg__i    (m2r),
      .MemRead__i     (mr),
      .MemWrite__i    (mw),
      .ALUSrc__i      (alusrc),
      .RegDst__i      (regdst),
      .ALUOp__i       (aluop),
      .RegRsData__i   (rs_d),
      .RegRtData__i   (rt_d),
      .Immediate__i   (imm),
      .InstrRsAddr__i (rs_a),
      .InstrRtAddr__i (rt_a),
      .InstrRdAddr__i (rd_a),
      .WbRegWrite__i  (wb_we),
      .WbAddr__i      (wb_a),
      .WbData__i      (wb_d),
      .RegWrite__o    (rw_o),
      .MemToReg__o    (m2r_o),
      .MemRead__o     (mr_o),
      .MemWrite__o    (mw_o),
      .ALUResult__o   (res_o),
      .StoreData__o   (st_o),
      .DestAddr__o    (dst_o),
      .Stall__o       (stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic clr;
      rw = 0; m2r = 0; mr = 0; mw = 0; alusrc = 0; regdst = 0; aluop = 3'b000;
      rs_d = 0; rt_d = 0; imm = 0; rs_a = 0; rt_a = 0; rd_a = 0;
      wb_we = 0; wb_a = 0; wb_d = 0;
   endtask

   task automatic instr(input logic [2:0] op, input logic [4:0] ra, input logic [31:0] rv,
                        input logic [4:0] ta, input logic [31:0] tv, input logic src,
                        input logic [31:0] im, input logic dsel, input logic [4:0] rd,
                        input logic we);
      aluop = op; rs_a = ra; rs_d = rv; rt_a = ta; rt_d = tv; alusrc = src;
      imm = im; regdst = dsel; rd_a = rd; rw = we; m2r = 0; mr = 0; mw = 0;
   endtask

   function automatic logic [31:0] all_out();
      return {rw_o, m2r_o, mr_o, mw_o} | res_o | st_o | {27'd0, dst_o} | {31'd0, stall};
   endfunction

   task automatic run_mul(output int s, output int b);
      s = 0; b = 0;
      while (stall && s < 40) begin
         s++;
         tick;
         if ({rw_o, m2r_o, mr_o, mw_o} != 4'd0 || res_o != 0 || st_o != 0 || dst_o != 0) b++;
      end
   endtask

   initial begin
      clr;
      reset_n = 1'b0;
      tick; tick;
      chk("reset_outs", all_out(), 32'd0);
      reset_n = 1'b1;

      // ADD with register destination
      instr(3'b000, 5'd3, 32'd5, 5'd4, 32'd7, 0, 0, 1, 5'd8, 1);
      #1 chk("add_stall", {31'd0, stall}, 32'd0);
      tick;
      chk("add_res", res_o, 32'd12);
      chk("add_dst", {27'd0, dst_o}, 32'd8);
      chk("add_st", st_o, 32'd7);
      chk("add_ctl", {28'd0, rw_o, m2r_o, mr_o, mw_o}, 32'h8);

      instr(3'b001, 5'd3, 32'd5, 5'd4, 32'd7, 0, 0, 1, 5'd8, 1); tick;
      chk("sub_wrap", res_o, 32'hFFFF_FFFE);
      instr(3'b010, 5'd3, 32'hF0F0, 5'd4, 32'hFF00, 0, 0, 1, 5'd8, 1); tick;
      chk("and", res_o, 32'h0000_F000);
      instr(3'b011, 5'd3, 32'hF0F0, 5'd4, 32'hFF00, 0, 0, 1, 5'd8, 1); tick;
      chk("or", res_o, 32'h0000_FFF0);
      instr(3'b100, 5'd3, 32'hF0F0, 5'd4, 32'hFF00, 0, 0, 1, 5'd8, 1); tick;
      chk("xor", res_o, 32'h0000_0FF0);
      instr(3'b110, 5'd3, 32'hF0F0, 5'd4, 32'hFF00, 0, 0, 1, 5'd8, 1); tick;
      chk("nor", res_o, 32'hFFFF_000F);
      instr(3'b101, 5'd3, 32'hFFFF_FFFF, 5'd4, 32'd1, 0, 0, 1, 5'd8, 1); tick;
      chk("slt_neg", res_o, 32'd1);
      instr(3'b101, 5'd3, 32'd1, 5'd4, 32'hFFFF_FFFF, 0, 0, 1, 5'd8, 1); tick;
      chk("slt_pos", res_o, 32'd0);

      // immediate operand, Rt destination, load-style controls
      instr(3'b000, 5'd3, 32'd5, 5'd4, 32'd7, 1, 32'h100, 0, 5'd8, 1);
      m2r = 1; mr = 1; tick;
      chk("imm_res", res_o, 32'h105);
      chk("imm_dst", {27'd0, dst_o}, 32'd4);
      chk("ld_ctl", {28'd0, rw_o, m2r_o, mr_o, mw_o}, 32'hE);

      // forwarding priority
      instr(3'b000, 5'd1, 32'h10, 5'd0, 0, 1, 0, 1, 5'd5, 1); tick;
      chk("fwd_prev", res_o, 32'h10);
      wb_we = 1; wb_a = 5'd5; wb_d = 32'h20;
      instr(3'b000, 5'd5, 32'h99, 5'd0, 0, 1, 0, 1, 5'd6, 1); tick;
      chk("fwd_mem_prio", res_o, 32'h10);
      instr(3'b000, 5'd5, 32'h99, 5'd5, 32'h77, 1, 0, 1, 5'd0, 1); tick;
      chk("fwd_wb_rs", res_o, 32'h20);
      chk("fwd_wb_rt", st_o, 32'h20);
      wb_a = 5'd0;
      instr(3'b000, 5'd0, 32'd3, 5'd0, 32'd4, 0, 0, 1, 5'd0, 1); tick;
      chk("fwd_r0_res", res_o, 32'd7);
      chk("fwd_r0_st", st_o, 32'd4);
      wb_we = 0;

      clr; tick;
      chk("bubble", all_out(), 32'd0);

      // reset while idle with live outputs
      instr(3'b000, 5'd3, 32'd5, 5'd4, 32'd7, 0, 0, 1, 5'd8, 1); tick;
      reset_n = 1'b0; clr; #1;
      chk("rst_idle", all_out(), 32'd0);
      tick; reset_n = 1'b1;
      instr(3'b000, 5'd3, 32'd1, 5'd4, 32'd2, 0, 0, 1, 5'd8, 1); tick;
      chk("rst_idle_next", res_o, 32'd3);

`ifdef EX_MUL_EN
      instr(3'b111, 5'd10, 32'h0001_0003, 5'd11, 32'd5, 0, 0, 1, 5'd9, 1);
      #1 chk("mul_accept", {31'd0, stall}, 32'd1);
      run_mul(stalls, bub);
      chk("mul_stalls", stalls, 32'd32);
      chk("mul_bubbles", bub, 32'd0);
      tick;
      chk("mul_res", res_o, 32'h0005_000F);
      chk("mul_dst", {27'd0, dst_o}, 32'd9);
      chk("mul_ctl", {28'd0, rw_o, m2r_o, mr_o, mw_o}, 32'h8);

      // back-to-back, operand forwarded from WB then WB data changes
      wb_we = 1; wb_a = 5'd7; wb_d = 32'd6;
      instr(3'b111, 5'd7, 32'hDEAD, 5'd11, 32'd3, 0, 0, 1, 5'd12, 1);
      #1 chk("b2b_accept", {31'd0, stall}, 32'd1);
      tick;
      wb_d = 32'd100;
      run_mul(stalls, bub);
      chk("mul2_stalls", stalls, 32'd31);
      tick;
      chk("mul2_capture", res_o, 32'd18);
      wb_we = 0;
      instr(3'b111, 5'd10, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF, 0, 0, 1, 5'd13, 1);
      #1 chk("b2b_accept2", {31'd0, stall}, 32'd1);
      run_mul(stalls, bub);
      tick;
      chk("mul3_res", res_o, 32'd1);

      // reset at count 10 aborts the multiply
      instr(3'b111, 5'd10, 32'd7, 5'd11, 32'd9, 0, 0, 1, 5'd14, 1);
      for (int i = 0; i < 11; i++) tick;
      chk("mul_mid_stall", {31'd0, stall}, 32'd1);
      reset_n = 1'b0; clr; #1;
      chk("rst_mul", all_out(), 32'd0);
      tick; reset_n = 1'b1;
      instr(3'b000, 5'd3, 32'd2, 5'd4, 32'd3, 0, 0, 1, 5'd15, 1);
      #1 chk("rst_mul_nostall", {31'd0, stall}, 32'd0);
      tick;
      chk("rst_mul_next", res_o, 32'd5);
      clr; tick;
      chk("rst_mul_clean", all_out(), 32'd0);
`else
      instr(3'b111, 5'd3, 32'd3, 5'd4, 32'd5, 0, 0, 1, 5'd9, 1);
      #1 chk("nomul_stall", {31'd0, stall}, 32'd0);
      tick;
      chk("nomul_res", res_o, 32'd0);
      chk("nomul_dst", {27'd0, dst_o}, 32'd9);
      chk("nomul_stall2", {31'd0, stall}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. Resolves operand forwarding, performs the ALU operation selected by the 3-bit ALU opcode, and selects the destination register. Results and memory/writeback controls are registered into an internal EX/MEM register. An optional iterative multiplier stalls the front of the pipeline while it runs.

## Interface
Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, multiplier iterations; must equal XLEN.

Ports:
- clock__i  in  1  pipeline clock, rising edge.
- reset_n__i  in  1  reset, asynchronous, active-low.
- RegWrite__i, MemToReg__i, MemRead__i, MemWrite__i, ALUSrc__i, RegDst__i  in  1 each  controls from ID/EX.
- ALUOp__i  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 NOR, 111 MUL.
- RegRsData__i, RegRtData__i, Immediate__i  in  XLEN each  operands from ID/EX.
- InstrRsAddr__i, InstrRtAddr__i, InstrRdAddr__i  in  5 each  register addresses.
- WbRegWrite__i  in  1  MEM/WB write enable, for forwarding.
- WbAddr__i  in  5  MEM/WB destination.
- WbData__i  in  XLEN  MEM/WB writeback data.
- RegWrite__o, MemToReg__o, MemRead__o, MemWrite__o  out  1 each  registered EX/MEM controls.
- ALUResult__o  out  XLEN  registered ALU result / memory address.
- StoreData__o  out  XLEN  registered forwarded Rt value.
- DestAddr__o  out  5  registered destination (RegDst ? Rd : Rt).
- Stall__o  out  1  combinational; freezes PC, IF/ID and ID/EX while high.

## Operation
- Forwarding, per operand (Rs, Rt): when the address is 0, use the ID/EX value. Otherwise forward the EX/MEM result when RegWrite__o is 1 and DestAddr__o matches. Failing that, forward WbData__i when WbRegWrite__i is 1 and WbAddr__i matches. Failing both, use the ID/EX value. EX/MEM has priority over MEM/WB.
- Operand B = ALUSrc__i ? Immediate__i : forwarded Rt.
- ALU results are XLEN-bit, and carries and overflow are discarded. SLT yields 1 or 0, zero-extended.
- FSM states are IDLE and BUSY.
  - IDLE with ALUOp__i = 111: latch forwarded Rs and operand B, clear the accumulator, set count = 0, go to BUSY, drive Stall__o high.
  - BUSY: one shift-add step per cycle. Stall__o stays high while count < MUL_CYCLES-1.
  - At count = MUL_CYCLES-1: Stall__o is low, the low XLEN bits of the product plus controls are registered into EX/MEM, and the FSM returns to IDLE.
- While Stall__o is high, EX/MEM loads a bubble: all controls 0, data 0, DestAddr 0.
- Non-MUL opcodes complete in IDLE in one cycle and never assert Stall__o.

## Timing
- Reset: every registered output is 0, the FSM is IDLE, count is 0, and Stall__o is 0.
- Reset asserted mid-multiply aborts the operation immediately, with no partial result written.
- Single-cycle ops: inputs in cycle N appear on the outputs after the edge ending cycle N.
- MUL accepted in cycle N:
  - Stall__o is high in cycles N through N+MUL_CYCLES-1.
  - The result appears after the edge ending cycle N+MUL_CYCLES.
  - Total occupancy is MUL_CYCLES+1 cycles.
- MUL operands are captured at acceptance. Later changes on the forwarding inputs have no effect on the result.
- Back-to-back MUL: the second is accepted in the cycle immediately after the first completes.
- A bubble input (all zero, ALUOp 000) produces an all-zero EX/MEM entry.

## Configuration
- EX_MUL_EN defined: multiplier and FSM are present, and ALUOp 111 behaves as specified above.
- EX_MUL_EN undefined:
  - ALUOp 111 completes in one cycle with ALUResult__o = 0.
  - Stall__o is tied to 0 and no FSM is instantiated.

## Structure
- Package ex_pkg holds:
  - the alu_op_t enum (the eight encodings above);
  - the ex_state_t enum (IDLE, BUSY);
  - the XLEN and MUL_CYCLES default constants.
- Sub-module ex_mul_seq: shift-add multiplier with start, busy and done signals plus operand/result ports. Only instantiated under EX_MUL_EN.
- Forwarding muxes, ALU and EX/MEM register live in ex_stage.

## Test plan
- Reset while idle, and separately during MUL count = 10 -> all outputs 0, Stall__o 0, next instruction executes normally.
- ADD with Rs=3 (value 5) and Rt=4 (value 7), RegDst=1, Rd=8 -> ALUResult__o = 12 and DestAddr__o = 8 one cycle later. SLT with -1 vs 1 -> 1.
- Forwarding priority:
  - Previous instruction writes r5 = 0x10; WbAddr__i = 5 with WbData__i = 0x20; current instruction reads Rs=5 -> uses 0x10.
  - Address 0 with matching writes -> uses the ID/EX value.
- MUL 0x0001_0003 × 0x0000_0005 (EX_MUL_EN defined):
  - Stall__o is high for exactly 32 cycles.
  - Bubbles appear on EX/MEM during the stall.
  - ALUResult__o = 0x0005_000F after cycle 33.
- MUL with operand forwarded from WB, then WbData__i changed mid-operation -> result uses the captured value. Back-to-back MULs both complete correctly.
- EX_MUL_EN undefined: ALUOp 111 -> ALUResult__o = 0 and Stall__o never asserted.
